// File: rtl/keypad_entry_if.sv
// rtl/keypad_entry_if.sv - keypad code input and operand-entry outputs
interface keypad_entry_if;
  logic [3:0]  key_code;
  logic        clear_in;
  logic        key_strobe;
  logic [3:0]  key_value;
  logic [3:0]  cur_val;
  logic [2:0]  num_count;
  logic [15:0] num_flat;
  logic        entry_done;
  logic        entry_err;

  // Driver side: keypad decoder / round control
  modport master (
    output key_code,
    output clear_in,
    input  key_strobe,
    input  key_value,
    input  cur_val,
    input  num_count,
    input  num_flat,
    input  entry_done,
    input  entry_err
  );

  // Entry block side
  modport slave (
    input  key_code,
    input  clear_in,
    output key_strobe,
    output key_value,
    output cur_val,
    output num_count,
    output num_flat,
    output entry_done,
    output entry_err
  );
endinterface

// File: rtl/keypad_entry.sv
// rtl/keypad_entry.sv - debounced keypad events assembled into four operands
module keypad_entry #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20,
  parameter int MAX_VAL         = 13
) (
  input  logic          clk,
  input  logic          rst,
  keypad_entry_if.slave kp
);

  typedef enum logic {
    COLLECT = 1'b0,
    DONE    = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0]       MAX_T    = 8'(MAX_VAL);
  localparam logic [3:0]       KEY_A    = 4'hA;
  localparam logic [3:0]       KEY_B    = 4'hB;
  localparam logic [3:0]       KEY_C    = 4'hC;

  // Debouncer state
  logic [3:0]       code_q;
  logic [3:0]       cand;
  logic [3:0]       accepted;
  logic [CNT_W-1:0] cnt;
  logic             strobe_q;
  logic [3:0]       value_q;

  // Entry state
  state_t      state;
  state_t      state_nxt;
  logic [3:0]  cur_q;
  logic [2:0]  count_q;
  logic [15:0] flat_q;
  logic        err_q;
  logic        done;

  // Decoded action for the current strobe
  logic        key_is_digit;
  logic [7:0]  digit_t;
  logic        do_clear;
  logic        do_digit;
  logic        do_commit;
  logic        do_back;
  logic        do_err;

  // One register stage on the keypad code before it is compared
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_q <= 4'd0;
    end else begin
      code_q <= kp.key_code;
    end
  end

  // Restart the stability count on any change; fire once when a new code settles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand     <= 4'd0;
      accepted <= 4'd0;
      cnt      <= '0;
      strobe_q <= 1'b0;
      value_q  <= 4'd0;
    end else begin
      strobe_q <= 1'b0;
      if (code_q != cand) begin
        cand <= code_q;
        cnt  <= '0;
      end else if (cnt == CNT_LAST) begin
        // Counter parks here; the accepted compare blocks repeat events
        if (cand != accepted) begin
          accepted <= cand;
          strobe_q <= 1'b1;
          value_q  <= cand;
        end
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign key_is_digit = (value_q <= 4'd9);
  assign digit_t      = 8'(cur_q) * 8'd10 + 8'(value_q);

  // Classify the strobed key; clear_in overrides whatever the key asks for
  always_comb begin
    do_clear  = 1'b0;
    do_digit  = 1'b0;
    do_commit = 1'b0;
    do_back   = 1'b0;
    do_err    = 1'b0;
    if (kp.clear_in) begin
      do_clear = 1'b1;
    end else if (strobe_q) begin
      if (value_q == KEY_C) begin
        do_clear = 1'b1;
      end else if (state == DONE) begin
        // Operand set is complete: editing keys are rejected, D-F ignored
        do_err = key_is_digit || (value_q == KEY_A) || (value_q == KEY_B);
      end else if (key_is_digit) begin
        if (digit_t <= MAX_T) begin
          do_digit = 1'b1;
        end else begin
          do_err = 1'b1;
        end
      end else if (value_q == KEY_A) begin
        if (cur_q != 4'd0) begin
          do_commit = 1'b1;
        end else begin
          do_err = 1'b1;
        end
      end else if (value_q == KEY_B) begin
        do_back = 1'b1;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= COLLECT;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state: the fourth commit completes entry, any clear restarts it
  always_comb begin
    state_nxt = state;
    if (do_clear) begin
      state_nxt = COLLECT;
    end else if (do_commit && (count_q == 3'd3)) begin
      state_nxt = DONE;
    end
  end

  // FSM outputs
  always_comb begin
    done = (state == DONE);
  end

  // Operand datapath and the error pulse that trails the rejected strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_q   <= 4'd0;
      count_q <= 3'd0;
      flat_q  <= 16'd0;
      err_q   <= 1'b0;
    end else begin
      err_q <= do_err;
      if (do_clear) begin
        cur_q   <= 4'd0;
        count_q <= 3'd0;
        flat_q  <= 16'd0;
      end else if (do_digit) begin
        cur_q <= digit_t[3:0];
      end else if (do_commit) begin
        flat_q[{count_q[1:0], 2'b00} +: 4] <= cur_q;
        count_q <= count_q + 3'd1;
        cur_q   <= 4'd0;
      end else if (do_back) begin
        cur_q <= cur_q / 4'd10;
      end
    end
  end

  assign kp.key_strobe = strobe_q;
  assign kp.key_value  = value_q;
  assign kp.cur_val    = cur_q;
  assign kp.num_count  = count_q;
  assign kp.num_flat   = flat_q;
  assign kp.entry_done = done;
  assign kp.entry_err  = err_q;

endmodule

// File: tb/tb_keypad_entry.sv
// tb/tb_keypad_entry.sv - randomized scoreboard bench for keypad_entry
module tb_keypad_entry;

  localparam int DEB  = 4;
  localparam int MAXV = 13;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  keypad_entry_if kp();

  keypad_entry #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W(3),
    .MAX_VAL(MAXV)
  ) dut (
    .clk(clk),
    .rst(rst),
    .kp(kp)
  );

  typedef struct {
    int val;
    int at;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  strobe_cnt = 0;
  int  err_cnt = 0;

  // Reference model state
  int  run_val, run_len, acc;
  int  pend_val, pend_at;
  int  m_cur, m_cnt;
  int  m_slot[4];
  bit  m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] m_flat();
    return 16'(m_slot[3] * 4096 + m_slot[2] * 256 + m_slot[1] * 16 + m_slot[0]);
  endfunction

  function automatic void m_reset();
    run_val = 0; run_len = 0; acc = 0;
    pend_val = 0; pend_at = -1;
    m_cur = 0; m_cnt = 0; m_err = 0;
    foreach (m_slot[i]) m_slot[i] = 0;
    exp_q.delete();
  endfunction

  // Entry rules applied to one key event (or a clear)
  function automatic void m_apply(input bit clr, input bit act, input int k);
    int t;
    if (clr || (act && k == 12)) begin
      m_cur = 0; m_cnt = 0;
      foreach (m_slot[i]) m_slot[i] = 0;
    end else if (act) begin
      if (m_cnt == 4) begin
        if (k <= 11) m_err = 1;
      end else if (k <= 9) begin
        t = m_cur * 10 + k;
        if (t <= MAXV) m_cur = t; else m_err = 1;
      end else if (k == 10) begin
        if (m_cur == 0) m_err = 1;
        else begin
          m_slot[m_cnt] = m_cur;
          m_cnt++;
          m_cur = 0;
        end
      end else if (k == 11) begin
        m_cur = m_cur / 10;
      end
    end
  endfunction

  // Model: sees the same inputs the DUT samples on each rising edge
  initial begin
    m_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_reset();
      end else begin
        cyc++;
        m_err = 0;
        m_apply(kp.clear_in, pend_at == cyc, pend_val);
        if (int'(kp.key_code) == run_val) run_len++;
        else begin
          run_val = int'(kp.key_code);
          run_len = 1;
        end
        // A code sampled DEB+1 times in a row that differs from the last event
        if (run_len == DEB + 1 && run_val != acc) begin
          acc = run_val;
          exp_q.push_back('{val: run_val, at: cyc + 1});
          pend_val = run_val;
          pend_at  = cyc + 2;
        end
      end
    end
  end

  // Monitor: compares DUT outputs on the falling edge
  initial begin
    ev_t ev;
    forever begin
      @(negedge clk);
      if (kp.key_strobe === 1'b1) strobe_cnt++;
      if (kp.entry_err === 1'b1) err_cnt++;
      if (rst) begin
        chk("rst_strobe", kp.key_strobe, 0);
        chk("rst_value", kp.key_value, 0);
        chk("rst_cur", kp.cur_val, 0);
        chk("rst_count", kp.num_count, 0);
        chk("rst_flat", kp.num_flat, 0);
        chk("rst_done", kp.entry_done, 0);
        chk("rst_err", kp.entry_err, 0);
      end else begin
        if (exp_q.size() > 0 && exp_q[0].at == cyc) begin
          ev = exp_q.pop_front();
          chk("strobe", kp.key_strobe, 1);
          chk("key_value", kp.key_value, ev.val);
        end else begin
          chk("no_strobe", kp.key_strobe, 0);
        end
        chk("cur_val", kp.cur_val, m_cur);
        chk("num_count", kp.num_count, m_cnt);
        chk("num_flat", kp.num_flat, m_flat());
        chk("entry_done", kp.entry_done, m_cnt == 4);
        chk("entry_err", kp.entry_err, m_err);
      end
    end
  end

  int last_k = 0;

  task automatic drive(input int k, input int hold, input int clr_pct);
    kp.key_code = 4'(k);
    repeat (hold) begin
      kp.clear_in = ($urandom_range(0, 99) < clr_pct);
      @(posedge clk); #1;
    end
    kp.clear_in = 1'b0;
  endtask

  task automatic press(input int k);
    if (k == last_k) drive(13, 8, 0);
    drive(k, 8, 0);
    last_k = k;
  endtask

  initial begin
    int s0, e0, r, k, hold;
    bit found;
    kp.key_code = 4'd0;
    kp.clear_in = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Short glitch gives nothing, a held key gives exactly one event
    s0 = strobe_cnt;
    drive(5, 3, 0);
    drive(0, 6, 0);
    chk("t1_glitch", strobe_cnt - s0, 0);
    drive(5, 6, 0);
    drive(5, 4, 0);
    chk("t1_one_strobe", strobe_cnt - s0, 1);
    chk("t1_value", kp.key_value, 5);
    last_k = 5;
    drive(5, 1, 100);
    chk("t1_cleared", kp.cur_val, 0);

    // Two-digit operand and commit, then an out-of-range digit
    press(1);  chk("t2_cur1", kp.cur_val, 1);
    press(3);  chk("t2_cur13", kp.cur_val, 13);
    press(10); chk("t2_count", kp.num_count, 1);
    chk("t2_slot0", kp.num_flat[3:0], 13);
    press(1);
    e0 = err_cnt;
    press(4);
    chk("t2_err", err_cnt - e0, 1);
    chk("t2_cur_kept", kp.cur_val, 1);

    // Full set of four operands
    press(12);
    press(4); press(10); press(7); press(10); press(8); press(10);
    press(1); press(2); press(10);
    chk("t3_done", kp.entry_done, 1);
    chk("t3_count", kp.num_count, 4);
    chk("t3_flat", kp.num_flat, 16'hC874);
    e0 = err_cnt;
    press(5);
    chk("t3_done_err", err_cnt - e0, 1);
    chk("t3_flat_kept", kp.num_flat, 16'hC874);

    // Empty commit, backspace, ignored key
    press(12);
    e0 = err_cnt;
    press(10);
    chk("t4_empty_commit", err_cnt - e0, 1);
    press(1); press(2);
    chk("t4_cur12", kp.cur_val, 12);
    press(11);
    chk("t4_back", kp.cur_val, 1);
    e0 = err_cnt;
    press(13);
    chk("t4_ignored_err", err_cnt - e0, 0);
    chk("t4_ignored_cur", kp.cur_val, 1);

    // clear_in coinciding with a digit strobe
    kp.key_code = 4'd3;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (kp.key_strobe) found = 1'b1;
    end
    chk("t5_strobe_seen", found, 1);
    #1 kp.clear_in = 1'b1;
    @(posedge clk); #1 kp.clear_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("t5_cur", kp.cur_val, 0);
    chk("t5_value", kp.key_value, 3);
    last_k = 3;

    // Reset in the middle of debouncing a new code
    s0 = strobe_cnt;
    kp.key_code = 4'd7;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    kp.key_code = 4'd0;
    #1;
    chk("t5_rst_value", kp.key_value, 0);
    chk("t5_rst_strobe", kp.key_strobe, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("t5_no_strobe_after_rst", strobe_cnt - s0, 0);
    last_k = 0;

    // Randomized key streams with glitches, clears and resets
    for (int it = 0; it < 400; it++) begin
      r = $urandom_range(0, 99);
      if (r < 40) k = ($urandom_range(0, 9) < 7) ? $urandom_range(0, 3) : $urandom_range(0, 9);
      else if (r < 65) k = 10;
      else if (r < 75) k = 11;
      else if (r < 80) k = 12;
      else if (r < 90) k = $urandom_range(13, 15);
      else k = $urandom_range(0, 15);
      hold = $urandom_range(1, 10);
      if ($urandom_range(0, 79) == 0) begin
        rst = 1'b1;
        drive(k, 2, 0);
        rst = 1'b0;
      end
      drive(k, hold, ($urandom_range(0, 9) == 0) ? 20 : 0);
    end

    repeat (12) @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
